// File: rtl/freq_div_prog.sv
// Programmable frequency divider: counts prescaled base ticks and emits a one-cycle
// tick plus a 50% square wave every D base ticks; divisor changes land only on period boundaries.
module freq_div_prog #(
  parameter int WIDTH = 8,
  parameter int PRESC = 1
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tick_o,
  output logic             sq_o,
  output logic [WIDTH-1:0] div_act_o,
  output logic             run_o
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_d;
  logic             tick_d, sq_d;
  logic             btk, last;

  assign btk  = (pcnt_q == PLAST);
  assign last = (cnt_q == (div_act_o - WIDTH'(1)));

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_o;
    tick_d    = 1'b0;
    sq_d      = sq_o;
    case (state_q)
      IDLE: begin
        pcnt_d    = '0;
        cnt_d     = '0;
        div_act_d = div_i;
        if (en_i && (div_i != '0)) state_d = RUN;
      end
      RUN: begin
        // Disable wins over a coincident boundary: the pending tick is dropped.
        if (!en_i) begin
          state_d = IDLE;
          pcnt_d  = '0;
          cnt_d   = '0;
        end else if (btk) begin
          pcnt_d = '0;
          if (last) begin
            tick_d    = 1'b1;
            sq_d      = ~sq_o;
            cnt_d     = '0;
            div_act_d = div_i;
            if (div_i == '0) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      tick_o    <= 1'b0;
      sq_o      <= 1'b0;
      div_act_o <= '0;
      run_o     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      tick_o    <= tick_d;
      sq_o      <= sq_d;
      div_act_o <= div_act_d;
      run_o     <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for freq_div_prog: two instances (PRESC=1 and PRESC=3) share inputs and are
// checked every cycle against a period-length model counting raw clock cycles.
module tb_freq_div_prog;

  logic       clk_i = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd0;

  logic       a_tick, a_sq, a_run, b_tick, b_sq, b_run;
  logic [7:0] a_dact, b_dact;
  logic [21:0] obs_w;

  freq_div_prog #(.WIDTH(8), .PRESC(1)) dut_a (
    .clk_i(clk_i), .reset_n(reset_n), .en_i(en), .div_i(div),
    .tick_o(a_tick), .sq_o(a_sq), .div_act_o(a_dact), .run_o(a_run)
  );

  freq_div_prog #(.WIDTH(8), .PRESC(3)) dut_b (
    .clk_i(clk_i), .reset_n(reset_n), .en_i(en), .div_i(div),
    .tick_o(b_tick), .sq_o(b_sq), .div_act_o(b_dact), .run_o(b_run)
  );

  assign obs_w = {a_tick, a_sq, a_run, a_dact, b_tick, b_sq, b_run, b_dact};

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference: a period lasts div*presc clock cycles, counted directly in clocks.
  int m_pr[2] = '{1, 3};
  bit m_run[2];
  int m_el[2];
  int m_dact[2];
  bit m_sq[2];
  bit m_tick[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_el[k] = 0; m_dact[k] = 0; m_sq[k] = 0; m_tick[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_run[k] = 0; m_el[k] = 0; m_dact[k] = 0; m_sq[k] = 0; m_tick[k] = 0;
      end else if (!m_run[k]) begin
        m_tick[k] = 0; m_el[k] = 0; m_dact[k] = int'(div);
        if (en && div != 0) m_run[k] = 1;
      end else if (!en) begin
        m_run[k] = 0; m_el[k] = 0; m_tick[k] = 0;
      end else if (m_el[k] == m_dact[k] * m_pr[k] - 1) begin
        m_tick[k] = 1; m_sq[k] = !m_sq[k]; m_el[k] = 0; m_dact[k] = int'(div);
        if (div == 0) m_run[k] = 0;
      end else begin
        m_tick[k] = 0; m_el[k]++;
      end
    end
  endtask

  function automatic logic [21:0] model_vec();
    return {m_tick[0], m_sq[0], m_run[0], 8'(m_dact[0]),
            m_tick[1], m_sq[1], m_run[1], 8'(m_dact[1])};
  endfunction

  task automatic clk_step();
    @(posedge clk_i);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; div = 8'd0;
    model_reset();
    repeat (3) clk_step();
    total++;
    if (obs_w !== 22'h0) begin
      bad++; $display("FAIL reset_vals cyc=%0d got=%h want=%h", cyc, obs_w, 22'h0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int r0 = -1, last = -1, nt = 0;
    en = 1'b1; div = 8'd4;
    for (int i = 0; i < 40; i++) begin
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL basic_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
      if (a_run && r0 < 0) r0 = cyc;
      if (a_tick) begin
        total++;
        if (last < 0 && (cyc - r0) != 4) begin
          bad++; $display("FAIL basic_first_tick got=%0d want=4", cyc - r0);
        end else if (last >= 0 && (cyc - last) != 4) begin
          bad++; $display("FAIL basic_interval got=%0d want=4", cyc - last);
        end
        last = cyc; nt++;
      end
    end
    total++;
    if (nt != 9) begin
      bad++; $display("FAIL basic_tick_count got=%0d want=9", nt);
    end
    en = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_change();
    int r0, exp_at = 4;
    bit seen = 0;
    div = 8'd4; en = 1'b1;
    for (int i = 0; i < 5 && !a_run; i++) clk_step();
    total++;
    if (!a_run) begin
      bad++; $display("FAIL change_start got=%0d want=1", a_run);
    end
    r0 = cyc;
    clk_step();
    div = 8'd2;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL change_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
      if (!seen) begin
        total++;
        if (a_dact !== (a_tick ? 8'd2 : 8'd4)) begin
          bad++; $display("FAIL change_dact cyc=%0d got=%0d want=%0d", cyc, a_dact, a_tick ? 2 : 4);
        end
        if (a_tick) seen = 1;
      end
      if (a_tick) begin
        total++;
        if ((cyc - r0) != exp_at) begin
          bad++; $display("FAIL change_tick_pos got=%0d want=%0d", cyc - r0, exp_at);
        end
        exp_at += 2;
      end
    end
    en = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_presc();
    for (int p = 0; p < 2; p++) begin
      int dv = (p == 0) ? 2 : 1;
      int la = -1, lb = -1;
      en = 1'b0;
      repeat (2) clk_step();
      div = 8'(dv); en = 1'b1;
      for (int i = 0; i < 36; i++) begin
        clk_step();
        total++;
        if (obs_w !== model_vec()) begin
          bad++; $display("FAIL presc_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
        end
        if (a_tick) begin
          if (la >= 0) begin
            total++;
            if ((cyc - la) != dv) begin
              bad++; $display("FAIL presc_a_interval got=%0d want=%0d", cyc - la, dv);
            end
          end
          la = cyc;
        end
        if (b_tick) begin
          if (lb >= 0) begin
            total++;
            if ((cyc - lb) != 3 * dv) begin
              bad++; $display("FAIL presc_b_interval got=%0d want=%0d", cyc - lb, 3 * dv);
            end
          end
          lb = cyc;
        end
      end
      total++;
      if (lb < 0) begin
        bad++; $display("FAIL presc_b_ticks got=none want=some");
      end
    end
    en = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_zero();
    int na = 0, nb = 0;
    reset_n = 1'b0; model_reset();
    div = 8'd0; en = 1'b1;
    clk_step();
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      clk_step();
      total++;
      if (obs_w !== 22'h0) begin
        bad++; $display("FAIL zero_idle cyc=%0d got=%h want=%h", cyc, obs_w, 22'h0);
      end
    end
    div = 8'd4;
    for (int i = 0; i < 5 && !a_run; i++) clk_step();
    repeat (2) clk_step();
    div = 8'd0;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL zero_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
      if (a_tick) na++;
      if (b_tick) nb++;
    end
    total++;
    if (na != 1 || nb != 1 || a_run !== 1'b0 || b_run !== 1'b0) begin
      bad++; $display("FAIL zero_final got=na%0d nb%0d run%0d%0d want=na1 nb1 run00", na, nb, a_run, b_run);
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    repeat (2) clk_step();
    div = 8'd3; en = 1'b1;
    for (int i = 0; i < 5 && !a_run; i++) clk_step();
    repeat (2) clk_step();
    en = 1'b0;
    clk_step();
    total++;
    if (a_tick !== 1'b0 || a_run !== 1'b0) begin
      bad++; $display("FAIL en_drop got=tick%0d run%0d want=tick0 run0", a_tick, a_run);
    end
    total++;
    if (obs_w !== model_vec()) begin
      bad++; $display("FAIL en_drop_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
    end
    div = 8'd5; en = 1'b1;
    repeat (4) clk_step();
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (obs_w !== 22'h0) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs_w, 22'h0);
    end
    model_reset();
    repeat (2) clk_step();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL restart_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
    end
  endtask

  task automatic test_max();
    int la = -1, lb = -1;
    en = 1'b0;
    repeat (2) clk_step();
    div = 8'd255; en = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL max_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
      if (a_tick) begin
        if (la >= 0) begin
          total++;
          if ((cyc - la) != 255) begin
            bad++; $display("FAIL max_a_interval got=%0d want=255", cyc - la);
          end
        end
        la = cyc;
      end
      if (b_tick) begin
        if (lb >= 0) begin
          total++;
          if ((cyc - lb) != 765) begin
            bad++; $display("FAIL max_b_interval got=%0d want=765", cyc - lb);
          end
        end
        lb = cyc;
      end
    end
    en = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) div = 8'($urandom_range(0, 6));
      clk_step();
      total++;
      if (obs_w !== model_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_w, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_presc();
    test_zero();
    test_en_drop();
    test_max();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
